// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-fetch responder: NOP constant,
// fault encoding, FSM states and the fetch-address fault classifier.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    // Misalignment takes priority; the full upper address is compared so
    // high PCs never alias back into the store.
    function automatic fault_e classify_fault(input logic [31:0] addr,
                                              input int unsigned depth_words);
        if (addr[1:0] != 2'b00) return FAULT_MISALIGN;
        if ({2'b00, addr[31:2]} >= 32'(depth_words)) return FAULT_RANGE;
        return FAULT_OK;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction store: 1-write/1-read synchronous RAM, read-before-write.
// Ports: clk; we/waddr/wdata write port; re/raddr read port, rdata
// registered on the edge where re is high. Contents are never reset.
module imem_array #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [31:0]                    wdata,
    input  logic                           re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Same-edge read and write both sample the old contents.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts one fetch at a time, classifies the
// PC for faults, reads the instruction store and holds the response until
// the requester consumes it. A program loader may write the store any cycle.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/req_ready  fetch request handshake, req_addr = byte PC
//   rsp_valid/rsp_ready  response handshake, rsp_instr/rsp_fault payload
//   ld_en/ld_addr/ld_data loader write port (word index)
//   busy                 high whenever the FSM is not idle
module imem_responder
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] NOP_WORD    = NOP_INSTR
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_instr,
    output logic [1:0]                     rsp_fault,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_data,
    output logic                           busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_e      state;
    logic [31:0] addr_q;
    fault_e      fault_q;
    fault_e      fault_c;
    logic        rd_en;
    logic [31:0] rd_data;

    // Loader has priority over new fetches so a write never races an accept.
    assign req_ready = (state == ST_IDLE) && !ld_en;

    assign fault_c = classify_fault(addr_q, DEPTH_WORDS);
    // Faulted fetches never touch the array.
    assign rd_en   = (state == ST_READ) && (fault_c == FAULT_OK);

    imem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (ld_en && rst_n),
        .waddr(ld_addr),
        .wdata(ld_data),
        .re   (rd_en),
        .raddr(addr_q[AW+1:2]),
        .rdata(rd_data)
    );

    // Fetch FSM; RESPOND spends one cycle loading the response registers,
    // then holds them until the rsp handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            fault_q   <= FAULT_OK;
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_fault <= 2'b00;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q <= req_addr;
                        state  <= ST_READ;
                        busy   <= 1'b1;
                    end
                end
                ST_READ: begin
                    fault_q <= fault_c;
                    state   <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_instr <= (fault_q != FAULT_OK) ? NOP_WORD : rd_data;
                        rsp_fault <= fault_q;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the instruction store size in 32-bit words (power of two).
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0013, meaning the word returned on fault (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  fetch request present.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_addr  input  32  byte address (PC) of the fetch.
REQ-008 SHALL have port rsp_valid  output  1  rsp_instr/rsp_fault valid.
REQ-009 SHALL have port rsp_ready  input  1  requester consumes the response.
REQ-010 SHALL have port rsp_instr  output  32  fetched instruction word.
REQ-011 SHALL have port rsp_fault  output  2  00 ok, 01 misaligned, 10 out-of-range.
REQ-012 SHALL have port ld_en  input  1  program-loader write strobe.
REQ-013 SHALL have port ld_addr  input  $clog2(DEPTH_WORDS)  word index for the loader write.
REQ-014 SHALL have port ld_data  input  32  word to write.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM IDLE, READ, RESPOND; IDLE->READ on req_valid&&req_ready; READ->RESPOND unconditionally; RESPOND->IDLE on rsp_ready.
REQ-017 SHALL drive req_ready = (state==IDLE) && !ld_en; one outstanding request maximum.
REQ-018 SHALL register req_addr on the accept edge; later req_addr changes SHALL NOT affect the response.
REQ-019 SHALL assert rsp_valid exactly 2 cycles after the accept edge (accept at edge N, rsp_valid high after edge N+2) and hold rsp_valid, rsp_instr, rsp_fault stable until the rsp_ready edge.
REQ-020 SHALL deassert rsp_valid on the edge where rsp_valid&&rsp_ready; no back-to-back responses (next accept earliest in the following IDLE cycle).
REQ-021 SHALL classify fault: addr[1:0]!=0 -> 01; else addr[31:2] >= DEPTH_WORDS -> 10; misaligned wins if both.
REQ-022 SHALL return NOP_WORD on rsp_instr when rsp_fault!=00, and SHALL NOT read the array for faulted requests.
REQ-023 SHALL index the array with addr[$clog2(DEPTH_WORDS)+1:2] for non-faulted requests.
REQ-024 SHALL perform loader writes on any edge with ld_en high, in every state.
REQ-025 SHALL capture array data on the READ->RESPOND edge; a loader write to the same index on that edge SHALL return the old word (read-before-write).
REQ-026 SHALL not alter array contents on reads; address 0xFFFF_FFFC SHALL report fault 10, never wrap.

Reset
REQ-027 SHALL on rst_n low at a clock edge force state IDLE, rsp_valid 0, rsp_instr 0, rsp_fault 00, busy 0, abandoning any in-flight request.
REQ-028 SHALL NOT clear array contents on reset; ld_en SHALL be ignored while rst_n is low.

Structure
REQ-029 SHALL place the NOP constant, fault encoding enum and FSM state enum in shared package rv_pkg.
REQ-030 SHALL instantiate one sub-module imem_array: 1-write/1-read synchronous RAM, DEPTH_WORDS x 32, read-before-write.

Verification
REQ-031 Load word 0 = 32'h0020_8133, request addr 0x0 -> rsp_valid 2 cycles after accept, rsp_instr 32'h0020_8133, fault 00.
REQ-032 Request addr 0x6 -> rsp_instr 32'h0000_0013, fault 01; request addr 0x400 (DEPTH 256) -> fault 10.
REQ-033 Hold rsp_ready low 5 cycles after rsp_valid -> outputs stable, req_ready 0, busy 1 throughout.
REQ-034 ld_en high with req_valid in IDLE -> req_ready 0, no accept; accepted next cycle after ld_en drops.
REQ-035 Word 5 = 0xA, request 0x14, loader writes 0xB to index 5 on READ->RESPOND edge -> rsp_instr 0xA; repeat fetch -> 0xB.
REQ-036 Assert rst_n low during READ -> next cycle IDLE, rsp_valid 0; refetch of word 0 still returns loaded value.
